data_island_packet_assembler: RTL and testbench

Serializes one HDMI data island packet (24-bit header plus four 56-bit subpackets, e.g. from the vendor-specific or SPD InfoFrame generators) into the 9-bit-per-clock stream consumed by the TERC4 channel encoders. It computes and appends the BCH ECC parity bits (header BCH(32,24), subpackets BCH(64,56)) serially as bits are shifted out, over 32 pixel clocks per packet. It sits between the packet picker and the TMDS channel encoders.

---
 rtl/hdmi_pkg.sv | 18 +
 rtl/data_island_packet_assembler_if.sv | 21 ++
 rtl/data_island_packet_assembler_bch.sv | 36 +++
 rtl/data_island_packet_assembler.sv | 93 +++++++++
 tb/tb_data_island_packet_assembler.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI data island packet geometry, subpacket bundle type and the serial BCH step.
package hdmi_pkg;

  localparam logic [7:0] BCH_POLY          = 8'h83;
  localparam int         PACKET_SLOTS      = 32;
  localparam int         HEADER_DATA_SLOTS = 24;
  localparam int         SUB_DATA_SLOTS    = 28;

  typedef logic [3:0][55:0] sub_t;

  // One bit of the LSB-first BCH shift register used by both header and subpacket lanes.
  function automatic logic [7:0] next_ecc(input logic [7:0] ecc, input logic b);
    logic fb;
    fb = ecc[0] ^ b;
    return (ecc >> 1) ^ (fb ? BCH_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/data_island_packet_assembler_if.sv
// Packet contents in from the packet picker, serialized 9-bit slots out to the TERC4 encoders.
interface data_island_packet_assembler_if
  import hdmi_pkg::*;
  ();
  logic        data_island_period;
  logic [23:0] header;
  sub_t        sub;
  logic [8:0]  packet_data;
  logic        packet_start;
  logic        packet_end;

  modport master (
    output data_island_period, header, sub,
    input  packet_data, packet_start, packet_end
  );

  modport slave (
    input  data_island_period, header, sub,
    output packet_data, packet_start, packet_end
  );
endinterface

// File: rtl/data_island_packet_assembler_bch.sv
// Serial BCH parity register consuming BITS_PER_CLK bits per enabled cycle, bit 0 first.
// The new value is visible one cycle after the bits are presented.
module bch_ecc_serial
  import hdmi_pkg::*;
#(
  parameter int BITS_PER_CLK = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [BITS_PER_CLK-1:0] data,
  output logic [7:0]              ecc
);

  logic [7:0] ecc_next;

  // clear together with enable restarts the code word from a zero seed with this cycle's bits
  always_comb begin
    ecc_next = clear ? 8'h00 : ecc;
    for (int k = 0; k < BITS_PER_CLK; k++) begin
      ecc_next = next_ecc(ecc_next, data[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ecc <= 8'h00;
    end else if (enable) begin
      ecc <= ecc_next;
    end else if (clear) begin
      ecc <= 8'h00;
    end
  end

endmodule

// File: rtl/data_island_packet_assembler.sv
// Serializes a 24-bit header plus four 56-bit subpackets with BCH parity over 32 slots.
// One cycle from the slot-0 inputs to slot-0 output; all outputs registered.
module data_island_packet_assembler
  import hdmi_pkg::*;
(
  input logic                          clk_pixel,
  input logic                          reset,
  data_island_packet_assembler_if.slave bus
);

  logic [4:0]       slot;
  logic [23:0]      hdr_sh;
  sub_t             sub_sh;
  logic [23:0]      hdr_cur;
  sub_t             sub_cur;
  logic [7:0]       ecc_hdr;
  logic [3:0][7:0]  ecc_sub;
  logic [8:0]       pd_next;
  logic [5:0]       pair_idx;
  logic [2:0]       par_idx;
  logic             first;
  logic             hdr_data_slot;
  logic             sub_data_slot;
  logic             ecc_clear;
  logic             hdr_en;
  logic             sub_en;

  assign first         = (slot == 5'd0);
  assign hdr_data_slot = (slot < 5'(HEADER_DATA_SLOTS));
  assign sub_data_slot = (slot < 5'(SUB_DATA_SLOTS));
  assign pair_idx      = {slot, 1'b0};
  assign par_idx       = {slot[1:0], 1'b0};
  assign ecc_clear     = !bus.data_island_period || first;
  assign hdr_en        = bus.data_island_period && hdr_data_slot;
  assign sub_en        = bus.data_island_period && sub_data_slot;

  // Slot 0 works from the live inputs so no extra capture cycle is needed
  always_comb begin
    hdr_cur = first ? bus.header : hdr_sh;
    sub_cur = first ? bus.sub    : sub_sh;
    pd_next = '0;
    pd_next[0] = hdr_data_slot ? hdr_cur[slot] : ecc_hdr[slot[2:0]];
    for (int i = 0; i < 4; i++) begin
      pd_next[2*i+1 +: 2] = sub_data_slot ? sub_cur[i][pair_idx +: 2] : ecc_sub[i][par_idx +: 2];
    end
  end

  bch_ecc_serial #(.BITS_PER_CLK(1)) u_ecc_hdr (
    .clk    (clk_pixel),
    .reset  (reset),
    .clear  (ecc_clear),
    .enable (hdr_en),
    .data   (hdr_cur[slot]),
    .ecc    (ecc_hdr)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sub_ecc
    bch_ecc_serial #(.BITS_PER_CLK(2)) u_ecc_sub (
      .clk    (clk_pixel),
      .reset  (reset),
      .clear  (ecc_clear),
      .enable (sub_en),
      .data   (sub_cur[g][pair_idx +: 2]),
      .ecc    (ecc_sub[g])
    );
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      slot             <= 5'd0;
      hdr_sh           <= '0;
      sub_sh           <= '0;
      bus.packet_data  <= 9'h000;
      bus.packet_start <= 1'b0;
      bus.packet_end   <= 1'b0;
    end else if (!bus.data_island_period) begin
      slot             <= 5'd0;
      bus.packet_data  <= 9'h000;
      bus.packet_start <= 1'b0;
      bus.packet_end   <= 1'b0;
    end else begin
      slot             <= slot + 5'd1;
      bus.packet_data  <= pd_next;
      bus.packet_start <= first;
      bus.packet_end   <= (slot == 5'(PACKET_SLOTS - 1));
      if (first) begin
        hdr_sh <= bus.header;
        sub_sh <= bus.sub;
      end
    end
  end

endmodule

// File: tb/tb_data_island_packet_assembler.sv
// Random and directed packets compared against a whole-packet BCH reference model.
module tb_data_island_packet_assembler;
  import hdmi_pkg::*;

  logic clk_pixel = 1'b0;
  logic reset     = 1'b1;
  always #5 clk_pixel = ~clk_pixel;

  data_island_packet_assembler_if bus ();

  data_island_packet_assembler dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [8:0] exp_w [32];
  logic [8:0] obs_d [32];
  logic       obs_s [32];
  logic       obs_e [32];

  // Parity of an entire message, bit 0 first, straight from the generator rule
  function automatic logic [7:0] bch_parity(input logic [55:0] msg, input int nbits);
    logic [7:0] e;
    logic       fb;
    e = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      fb = e[0] ^ msg[i];
      e  = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
    end
    return e;
  endfunction

  // Each lane is its data followed by its parity; slot n carries the next bits of each lane
  task automatic model(input logic [23:0] h, input sub_t s);
    logic [31:0] hs;
    logic [63:0] ls [4];
    hs = {bch_parity({32'd0, h}, 24), h};
    for (int i = 0; i < 4; i++) ls[i] = {bch_parity(s[i], 56), s[i]};
    for (int n = 0; n < 32; n++) begin
      exp_w[n][0] = hs[n];
      for (int i = 0; i < 4; i++) begin
        exp_w[n][2*i+1] = ls[i][2*n];
        exp_w[n][2*i+2] = ls[i][2*n+1];
      end
    end
  endtask

  function automatic sub_t rand_sub();
    sub_t        s;
    logic [63:0] t;
    for (int i = 0; i < 4; i++) begin
      t    = {$urandom(), $urandom()};
      s[i] = t[55:0];
    end
    return s;
  endfunction

  function automatic logic [23:0] rand_hdr();
    logic [31:0] r;
    r = $urandom();
    return r[23:0];
  endfunction

  // Drives nslots high cycles starting at slot 0 and records the outputs of each slot
  task automatic run_packet(input logic [23:0] h, input sub_t s, input int nslots, input bit chg);
    for (int n = 0; n < nslots; n++) begin
      if (n == 0) begin
        bus.header = h;
        bus.sub    = s;
      end else if (chg && n == 5) begin
        bus.header = ~h;
        bus.sub    = rand_sub();
      end
      bus.data_island_period = 1'b1;
      @(posedge clk_pixel);
      #1;
      obs_d[n] = bus.packet_data;
      obs_s[n] = bus.packet_start;
      obs_e[n] = bus.packet_end;
    end
  endtask

  task automatic test_reset();
    bus.data_island_period = 1'b0;
    bus.header = '0;
    bus.sub    = '0;
    reset      = 1'b1;
    repeat (2) @(posedge clk_pixel);
    #1;
    n_total++;
    if ({bus.packet_data, bus.packet_start, bus.packet_end} !== 11'h000)
      $display("FAIL reset_state got %h/%b/%b exp 000/0/0", bus.packet_data, bus.packet_start, bus.packet_end);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_zero();
    model('0, '0);
    run_packet('0, '0, 32, 1'b0);
    for (int n = 0; n < 32; n++) begin
      n_total++;
      if ({obs_d[n], obs_s[n], obs_e[n]} !== {9'h000, n == 0, n == 31})
        $display("FAIL zero slot %0d got %h/%b/%b exp 000/%b/%b", n, obs_d[n], obs_s[n], obs_e[n], n == 0, n == 31);
      else n_pass++;
    end
  endtask

  task automatic test_vsif();
    sub_t s;
    s    = '0;
    s[0] = 56'h0002_01C4_5DD8_7D;
    model(24'h050181, s);
    run_packet(24'h050181, s, 32, 1'b0);
    for (int n = 0; n < 32; n++) begin
      n_total++;
      if ({obs_d[n], obs_s[n], obs_e[n]} !== {exp_w[n], n == 0, n == 31})
        $display("FAIL vsif slot %0d got %h/%b/%b exp %h/%b/%b", n, obs_d[n], obs_s[n], obs_e[n], exp_w[n], n == 0, n == 31);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 2; p++) begin
      logic [23:0] h;
      sub_t        s;
      h = rand_hdr();
      s = rand_sub();
      model(h, s);
      run_packet(h, s, 32, 1'b0);
      for (int n = 0; n < 32; n++) begin
        n_total++;
        if ({obs_d[n], obs_s[n], obs_e[n]} !== {exp_w[n], n == 0, n == 31})
          $display("FAIL b2b%0d slot %0d got %h/%b/%b exp %h/%b/%b", p, n, obs_d[n], obs_s[n], obs_e[n], exp_w[n], n == 0, n == 31);
        else n_pass++;
      end
    end
  endtask

  task automatic test_capture();
    logic [23:0] h;
    sub_t        s;
    h = rand_hdr();
    s = rand_sub();
    model(h, s);
    run_packet(h, s, 32, 1'b1);
    for (int n = 0; n < 32; n++) begin
      n_total++;
      if (obs_d[n] !== exp_w[n])
        $display("FAIL capture slot %0d got %h exp %h", n, obs_d[n], exp_w[n]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [23:0] h;
    sub_t        s;
    h = rand_hdr();
    s = rand_sub();
    model(h, s);
    run_packet(h, s, 10, 1'b0);
    for (int n = 0; n < 10; n++) begin
      n_total++;
      if (obs_d[n] !== exp_w[n])
        $display("FAIL abort_pre slot %0d got %h exp %h", n, obs_d[n], exp_w[n]);
      else n_pass++;
    end
    bus.data_island_period = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_pixel);
      #1;
      n_total++;
      if ({bus.packet_data, bus.packet_start, bus.packet_end} !== 11'h000)
        $display("FAIL abort_low cycle %0d got %h/%b/%b exp 000/0/0", c, bus.packet_data, bus.packet_start, bus.packet_end);
      else n_pass++;
    end
    h = rand_hdr();
    s = rand_sub();
    model(h, s);
    run_packet(h, s, 32, 1'b0);
    for (int n = 0; n < 32; n++) begin
      n_total++;
      if ({obs_d[n], obs_s[n], obs_e[n]} !== {exp_w[n], n == 0, n == 31})
        $display("FAIL abort_post slot %0d got %h/%b/%b exp %h/%b/%b", n, obs_d[n], obs_s[n], obs_e[n], exp_w[n], n == 0, n == 31);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] h;
    sub_t        s;
    h = rand_hdr();
    s = rand_sub();
    run_packet(h, s, 17, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({bus.packet_data, bus.packet_start, bus.packet_end} !== 11'h000)
      $display("FAIL reset_mid_async got %h/%b/%b exp 000/0/0", bus.packet_data, bus.packet_start, bus.packet_end);
    else n_pass++;
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    h = rand_hdr();
    s = rand_sub();
    model(h, s);
    run_packet(h, s, 32, 1'b0);
    for (int n = 0; n < 32; n++) begin
      n_total++;
      if ({obs_d[n], obs_s[n], obs_e[n]} !== {exp_w[n], n == 0, n == 31})
        $display("FAIL reset_mid_post slot %0d got %h/%b/%b exp %h/%b/%b", n, obs_d[n], obs_s[n], obs_e[n], exp_w[n], n == 0, n == 31);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      logic [23:0] h;
      sub_t        s;
      bit          chg;
      int          gap;
      gap = $urandom_range(0, 2);
      bus.data_island_period = 1'b0;
      repeat (gap) begin
        @(posedge clk_pixel);
        #1;
      end
      h   = rand_hdr();
      s   = rand_sub();
      chg = 1'($urandom_range(0, 1));
      model(h, s);
      run_packet(h, s, 32, chg);
      for (int n = 0; n < 32; n++) begin
        n_total++;
        if ({obs_d[n], obs_s[n], obs_e[n]} !== {exp_w[n], n == 0, n == 31})
          $display("FAIL random%0d slot %0d got %h/%b/%b exp %h/%b/%b", p, n, obs_d[n], obs_s[n], obs_e[n], exp_w[n], n == 0, n == 31);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_vsif();
    test_back_to_back();
    test_capture();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
